// File: rtl/bus_port_pkg.sv
// Shared constants and helpers for the bus port endpoint: destination
// extraction and saturating event counters.
package bus_port_pkg;
   localparam int ADDR_W = 8;
   localparam logic [ADDR_W-1:0] BROADCAST_DEF = 8'hFF;
   localparam int PKT_MAX = 64;

   // Packets are zero-extended to PKT_MAX bits; msb is the packet's top bit index.
   function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                                 input logic [5:0] msb);
      return pkt[msb -: ADDR_W];
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Full/empty come from a registered
// occupancy count. A write to a full FIFO succeeds when a read happens in the same cycle.
module sync_fifo_fwft #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);
   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   // Storage is not reset; the pointers alone define valid contents.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign empty   = (count == '0);
   assign full    = (count == CW'(depth));
   assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/bus_port_fifo.sv
// Device endpoint in front of one arbiter port: TX FIFO toward the bus,
// destination-filtered RX FIFO toward the host, plus saturating drop counters.
module bus_port_fifo
   import bus_port_pkg::*;
#(
   parameter int                pkg_size  = 16,
   parameter int                depth     = 8,
   parameter logic [ADDR_W-1:0] id        = 8'd0,
   parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [pkg_size-1:0]    wr_data,
   output logic                   tx_full,
   output logic [$clog2(depth):0] tx_count,
   output logic                   pndng,
   output logic [pkg_size-1:0]    D_pop,
   input  logic                   pop,
   input  logic                   push,
   input  logic [pkg_size-1:0]    D_push,
   output logic                   rx_valid,
   output logic [pkg_size-1:0]    rd_data,
   input  logic                   rd_en,
   output logic                   rx_full,
   output logic [$clog2(depth):0] rx_count,
   output logic [7:0]             tx_ovf_cnt,
   output logic [7:0]             rx_ovf_cnt,
   output logic [7:0]             misroute_cnt
);
   logic              tx_empty, rx_empty;
   logic [ADDR_W-1:0] dest;
   logic              match, rx_wr;

   assign dest  = dest_of(PKT_MAX'(D_push), 6'(pkg_size - 1));
   assign match = (dest == id) || (dest == broadcast);
   assign rx_wr = push && match;

   sync_fifo_fwft #(.width(pkg_size), .depth(depth)) u_tx (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(pop), .rd_data(D_pop),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   sync_fifo_fwft #(.width(pkg_size), .depth(depth)) u_rx (
      .clk(clk), .reset(reset),
      .wr_en(rx_wr), .wr_data(D_push),
      .rd_en(rd_en), .rd_data(rd_data),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   assign pndng    = !tx_empty;
   assign rx_valid = !rx_empty;

   // A full FIFO with a same-cycle dequeue accepts the write, so no drop is counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_ovf_cnt   <= '0;
         rx_ovf_cnt   <= '0;
         misroute_cnt <= '0;
      end else begin
         if (wr_en && tx_full && !pop)          tx_ovf_cnt   <= sat_inc8(tx_ovf_cnt);
         if (push && match && rx_full && !rd_en) rx_ovf_cnt   <= sat_inc8(rx_ovf_cnt);
         if (push && !match)                    misroute_cnt <= sat_inc8(misroute_cnt);
      end
   end
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed plus randomized check of bus_port_fifo against a queue-based model.
module tb_bus_port_fifo;
   localparam int DEPTH = 8;
   localparam int PW    = 16;

   logic          clk = 1'b0, reset = 1'b0;
   logic          wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0;
   logic [PW-1:0] wr_data = '0, D_push = '0;
   logic          tx_full, pndng, rx_valid, rx_full;
   logic [3:0]    tx_count, rx_count;
   logic [PW-1:0] D_pop, rd_data;
   logic [7:0]    tx_ovf_cnt, rx_ovf_cnt, misroute_cnt;

   int vectors = 0, errs = 0;

   logic [PW-1:0] txq[$], rxq[$];
   int m_tovf = 0, m_rovf = 0, m_mis = 0;

   bus_port_fifo #(.pkg_size(PW), .depth(DEPTH), .id(8'd3), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_valid(rx_valid), .rd_data(rd_data), .rd_en(rd_en),
      .rx_full(rx_full), .rx_count(rx_count),
      .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt), .misroute_cnt(misroute_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":tx_count"}, 32'(tx_count), 32'(txq.size()));
      chk({tag, ":pndng"},    32'(pndng),    32'(txq.size() != 0));
      chk({tag, ":tx_full"},  32'(tx_full),  32'(txq.size() == DEPTH));
      chk({tag, ":D_pop"},    32'(D_pop),    32'(txq.size() != 0 ? txq[0] : 16'h0));
      chk({tag, ":rx_count"}, 32'(rx_count), 32'(rxq.size()));
      chk({tag, ":rx_valid"}, 32'(rx_valid), 32'(rxq.size() != 0));
      chk({tag, ":rx_full"},  32'(rx_full),  32'(rxq.size() == DEPTH));
      chk({tag, ":rd_data"},  32'(rd_data),  32'(rxq.size() != 0 ? rxq[0] : 16'h0));
      chk({tag, ":tx_ovf"},   32'(tx_ovf_cnt),   32'(m_tovf));
      chk({tag, ":rx_ovf"},   32'(rx_ovf_cnt),   32'(m_rovf));
      chk({tag, ":misroute"}, 32'(misroute_cnt), 32'(m_mis));
   endtask

   // Model: apply one clock's worth of host and bus activity to the queues.
   task automatic model(input logic we, input logic [PW-1:0] wd, input logic pp,
                        input logic ps, input logic [PW-1:0] dp, input logic re);
      logic [7:0] d;
      bit tx_rd, rx_rd;
      tx_rd = pp && txq.size() > 0;
      rx_rd = re && rxq.size() > 0;
      if (tx_rd) void'(txq.pop_front());
      if (we) begin
         if (txq.size() < DEPTH) txq.push_back(wd);
         else if (m_tovf < 255) m_tovf++;
      end
      d = dp[15:8];
      if (rx_rd) void'(rxq.pop_front());
      if (ps) begin
         if (d != 8'd3 && d != 8'hFF) begin
            if (m_mis < 255) m_mis++;
         end else if (rxq.size() < DEPTH) rxq.push_back(dp);
         else if (m_rovf < 255) m_rovf++;
      end
   endtask

   task automatic step(input logic we, input logic [PW-1:0] wd, input logic pp,
                       input logic ps, input logic [PW-1:0] dp, input logic re);
      wr_en = we; wr_data = wd; pop = pp; push = ps; D_push = dp; rd_en = re;
      model(we, wd, pp, ps, dp, re);
      @(posedge clk); #1;
      check_all("step");
   endtask

   task automatic idle();
      wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1; #3; reset = 1'b0;
      txq.delete(); rxq.delete(); m_tovf = 0; m_rovf = 0; m_mis = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] dsel;
      int pw, pp, ps, pr;
      @(posedge clk); #1;
      do_reset();
      check_all("reset");

      // Two-packet TX ordering and drain to empty
      step(1, 16'h0101, 0, 0, 0, 0);
      chk("tp1_pndng", 32'(pndng), 1);
      chk("tp1_dpop0", 32'(D_pop), 32'h0101);
      step(1, 16'h0202, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("tp1_dpop1", 32'(D_pop), 32'h0202);
      step(0, 0, 1, 0, 0, 0);
      chk("tp1_empty", 32'(D_pop), 0);
      step(0, 0, 1, 0, 0, 0);  // pop on empty is ignored

      // TX full: drop, then write+pop acceptance
      for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h1000 + i), 0, 0, 0, 0);
      step(1, 16'hDEAD, 0, 0, 0, 0);
      chk("tx_full_ovf", 32'(tx_ovf_cnt), 1);
      step(1, 16'hBEEF, 1, 0, 0, 0);
      chk("tx_full_wrpop_cnt", 32'(tx_count), 8);
      chk("tx_full_wrpop_ovf", 32'(tx_ovf_cnt), 1);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0, 0);
      step(1, 16'h5555, 1, 0, 0, 0);  // write+pop while empty

      // RX filter: own id, broadcast, misroute
      step(0, 0, 0, 1, 16'h0355, 0);
      step(0, 0, 0, 1, 16'hFF66, 0);
      step(0, 0, 0, 1, 16'h0477, 0);
      chk("rx_misroute", 32'(misroute_cnt), 1);
      chk("rx_cnt2", 32'(rx_count), 2);
      chk("rx_head0", 32'(rd_data), 32'h0355);
      step(0, 0, 0, 0, 0, 1);
      chk("rx_head1", 32'(rd_data), 32'hFF66);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);  // read on empty is ignored

      // RX full: drop, then push+read acceptance
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 16'(16'h0300 + i), 0);
      step(0, 0, 0, 1, 16'h03AA, 0);
      chk("rx_full_ovf", 32'(rx_ovf_cnt), 1);
      step(0, 0, 0, 1, 16'hFFBB, 1);
      chk("rx_full_rdpush", 32'(rx_count), 8);
      step(0, 0, 0, 1, 16'h0901, 0);  // misroute while full still counted

      // Asynchronous reset with 4 TX / 3 RX entries held
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 16'(16'hA000 + i), 0, i < 3, 16'(16'h0310 + i), 0);
      chk("pre_rst_tx", 32'(tx_count), 4);
      chk("pre_rst_rx", 32'(rx_count), 3);
      idle();
      #2 reset = 1'b1;
      #1;
      chk("arst_pndng", 32'(pndng), 0);
      chk("arst_rxv", 32'(rx_valid), 0);
      chk("arst_txc", 32'(tx_count), 0);
      chk("arst_rxc", 32'(rx_count), 0);
      chk("arst_dpop", 32'(D_pop), 0);
      @(posedge clk); #1 reset = 1'b0;
      txq.delete(); rxq.delete(); m_tovf = 0; m_rovf = 0; m_mis = 0;
      check_all("post_arst");

      // Saturation of the TX overflow counter
      for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) step(1, 16'hEEEE, 0, 0, 0, 0);
      chk("tx_ovf_sat", 32'(tx_ovf_cnt), 255);
      do_reset();

      // Randomized traffic with phase-varied biases
      for (int ph = 0; ph < 6; ph++) begin
         pw = $urandom_range(10, 90); pp = $urandom_range(10, 90);
         ps = $urandom_range(10, 90); pr = $urandom_range(10, 90);
         for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
               0: dsel = 8'd3;
               1: dsel = 8'hFF;
               2: dsel = 8'd3;
               default: dsel = 8'($urandom);
            endcase
            step($urandom_range(0, 99) < pw, 16'($urandom), $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < ps, {dsel, 8'($urandom)}, $urandom_range(0, 99) < pr);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
